// File: rtl/max_sub_streamer.sv
// Streams saturated (x_i - max) in Q6.10, one lane per beat, from a captured N-lane vector.
// Optional define SUB_SKIP_INVALID_EN: lanes whose valid flag is clear are skipped entirely.
module max_sub_streamer #(
  parameter int N = 64,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_max,
  input  logic [N-1:0]      in_lane_valid,
  input  logic [N*16-1:0]   in_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_lane_valid,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [N-1:0][15:0]   lane_buf;
  logic [N-1:0][15:0]   in_lanes;
  logic [N-1:0]         lv_buf;
  logic [15:0]          max_buf;
  logic                 cap;
  logic                 ov_d, olv_d, ol_d;
  logic [15:0]          od_d;
  logic [IW-1:0]        oi_d, nxt;

  assign in_lanes = in_flat;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == STREAM);

  // 17-bit difference; sign bits disagreeing means the result left Q6.10 range.
  function automatic logic [15:0] sat_sub(input logic [15:0] x, input logic [15:0] m);
    logic [16:0] d;
    d = {x[15], x} - {m[15], m};
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

`ifdef SUB_SKIP_INVALID_EN
  // Lowest set flag strictly above 'after'; MSB of the result flags a hit.
  function automatic logic [IW:0] find_next(input logic [N-1:0] m, input int after);
    logic [IW:0] r;
    r = '0;
    for (int j = N-1; j >= 0; j--)
      if (j > after && m[j]) r = {1'b1, IW'(j)};
    return r;
  endfunction

  logic [IW:0] cap_first, cap_after, buf_next, buf_after;
  always_comb begin
    cap_first = find_next(in_lane_valid, -1);
    cap_after = find_next(in_lane_valid, int'(cap_first[IW-1:0]));
    buf_next  = find_next(lv_buf, int'(out_idx));
    buf_after = find_next(lv_buf, int'(buf_next[IW-1:0]));
  end
`endif

  always_comb begin
    state_d = state_q;
    ov_d    = out_valid;
    od_d    = out_data;
    oi_d    = out_idx;
    olv_d   = out_lane_valid;
    ol_d    = out_last;
    cap     = 1'b0;
    nxt     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap     = 1'b1;
          state_d = STREAM;
`ifdef SUB_SKIP_INVALID_EN
          // An all-clear vector loads no beat and falls back to IDLE next cycle.
          nxt   = cap_first[IW-1:0];
          ov_d  = cap_first[IW];
          oi_d  = nxt;
          od_d  = sat_sub(in_lanes[nxt], in_max);
          olv_d = 1'b1;
          ol_d  = ~cap_after[IW];
`else
          ov_d  = 1'b1;
          oi_d  = '0;
          od_d  = sat_sub(in_lanes[0], in_max);
          olv_d = in_lane_valid[0];
          ol_d  = 1'b0;
`endif
        end
      end
      STREAM: begin
        if (!out_valid) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (out_last) begin
            state_d = IDLE;
            ov_d    = 1'b0;
          end else begin
`ifdef SUB_SKIP_INVALID_EN
            nxt   = buf_next[IW-1:0];
            olv_d = 1'b1;
            ol_d  = ~buf_after[IW];
`else
            nxt   = out_idx + 1'b1;
            olv_d = lv_buf[nxt];
            ol_d  = (nxt == IW'(N-1));
`endif
            oi_d = nxt;
            od_d = sat_sub(lane_buf[nxt], max_buf);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_idx        <= '0;
      out_lane_valid <= 1'b0;
      out_last       <= 1'b0;
      lane_buf       <= '0;
      lv_buf         <= '0;
      max_buf        <= '0;
    end else begin
      state_q        <= state_d;
      out_valid      <= ov_d;
      out_data       <= od_d;
      out_idx        <= oi_d;
      out_lane_valid <= olv_d;
      out_last       <= ol_d;
      if (cap) begin
        lane_buf <= in_lanes;
        lv_buf   <= in_lane_valid;
        max_buf  <= in_max;
      end
    end
  end

endmodule

// File: tb/tb_max_sub_streamer.sv
// Table-driven scoreboard bench for max_sub_streamer at N=4.
module tb_max_sub_streamer;
  localparam int N = 4;

  logic            clk, rst_n;
  logic            in_valid, in_ready;
  logic [15:0]     in_max;
  logic [N-1:0]    in_lane_valid;
  logic [N*16-1:0] in_flat;
  logic            out_valid, out_ready;
  logic [15:0]     out_data;
  logic [1:0]      out_idx;
  logic            out_lane_valid, out_last, busy;

  max_sub_streamer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_max(in_max), .in_lane_valid(in_lane_valid), .in_flat(in_flat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .out_lane_valid(out_lane_valid), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       mx;
    logic [3:0][15:0]  lanes;
    logic [3:0]        lv;
    logic [3:0][15:0]  exp;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  idx;
    logic        lv;
    logic        last;
  } beat_t;

  vec_t  tbl[5];
  beat_t sb[$];
  int    total = 0;
  int    passed = 0;

  function automatic vec_t mk(input logic [15:0] mx, input logic [15:0] l0, l1, l2, l3,
                              input logic [3:0] lv, input logic [15:0] e0, e1, e2, e3);
    vec_t v;
    v.mx = mx;
    v.lanes[0] = l0; v.lanes[1] = l1; v.lanes[2] = l2; v.lanes[3] = l3;
    v.lv = lv;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic push_vec(input vec_t v);
    beat_t b;
`ifdef SUB_SKIP_INVALID_EN
    int hi = -1;
    for (int i = 0; i < 4; i++) if (v.lv[i]) hi = i;
    for (int i = 0; i < 4; i++)
      if (v.lv[i]) begin
        b = '{v.exp[i], 2'(i), 1'b1, (i == hi)};
        sb.push_back(b);
      end
`else
    for (int i = 0; i < 4; i++) begin
      b = '{v.exp[i], 2'(i), v.lv[i], (i == 3)};
      sb.push_back(b);
    end
`endif
  endtask

  task automatic send(input vec_t v);
    int w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    push_vec(v);
    in_max = v.mx; in_flat = v.lanes; in_lane_valid = v.lv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_capture", {31'd0, busy}, 32'd1);
    check("in_ready_low", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic cmp_beat();
    beat_t b;
    if (sb.size() == 0) begin
      check("unexpected_beat", 32'd1, 32'd0);
    end else begin
      b = sb.pop_front();
      check("beat_valid", {31'd0, out_valid}, 32'd1);
      check("beat_data", {16'd0, out_data}, {16'd0, b.d});
      check("beat_idx", {30'd0, out_idx}, {30'd0, b.idx});
      check("beat_lane_valid", {31'd0, out_lane_valid}, {31'd0, b.lv});
      check("beat_last", {31'd0, out_last}, {31'd0, b.last});
    end
  endtask

  // mode 0: ready high; 1: stall 3 cycles on idx1; 2: random ready
  task automatic drain(input int mode);
    int cyc = 0;
    int stalls = 0;
    logic [18:0] snap = '0;
    while (sb.size() > 0 && cyc < 200) begin
      if (mode == 1 && out_valid && out_idx == 2'd1 && stalls < 3) begin
        out_ready = 1'b0;
        if (stalls == 0) snap = {out_data, out_idx, out_last};
        else check("hold_stable", {13'd0, out_data, out_idx, out_last, out_valid}, {13'd0, snap, 1'b1});
        stalls++;
      end else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      if (out_valid && out_ready) cmp_beat();
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    if (mode == 1) check("stall_count", stalls, 32'd3);
    sb.delete();
    out_ready = 1'b0;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t lvv, zv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_max = '0; in_flat = '0; in_lane_valid = '0;

    tbl[0] = mk(16'h0800, 16'h0800, 16'h0400, 16'h0000, 16'hF800, 4'hF,
                16'h0000, 16'hFC00, 16'hF800, 16'hF000);
    tbl[1] = mk(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 16'h0001, 4'hF,
                16'h8000, 16'h8001, 16'h0000, 16'h8002);
    tbl[2] = mk(16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 4'hF,
                16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF);
    tbl[3] = mk(16'hFC00, 16'h0001, 16'hFC00, 16'h0400, 16'h8000, 4'hF,
                16'h0401, 16'h0000, 16'h0800, 16'h8400);
    tbl[4] = mk(16'h0000, 16'h1234, 16'hEDCC, 16'h7FFF, 16'h8000, 4'hF,
                16'h1234, 16'hEDCC, 16'h7FFF, 16'h8000);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_idx", {30'd0, out_idx}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send(tbl[i]);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      check("latency_idx0", {30'd0, out_idx}, 32'd0);
      drain(i == 3 ? 1 : (i == 4 ? 2 : 0));
    end

    // Reset after beat idx1 drops the vector.
    send(tbl[0]);
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      cmp_beat();
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    out_ready = 1'b0;
    send(tbl[1]);
    drain(0);

    // Partially valid vector.
    lvv = mk(16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'b0101,
             16'h0001, 16'h0002, 16'h0003, 16'h0004);
    send(lvv);
    drain(0);

    zv = mk(16'h0010, 16'h0010, 16'h0020, 16'h0000, 16'hFFF0, 4'b0000,
            16'h0000, 16'h0010, 16'hFFF0, 16'hFFE0);
`ifdef SUB_SKIP_INVALID_EN
    send(zv);
    check("zero_vec_no_beat", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("zero_vec_in_ready", {31'd0, in_ready}, 32'd1);
    check("zero_vec_busy", {31'd0, busy}, 32'd0);
    sb.delete();
`else
    send(zv);
    drain(2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
